// File: rtl/sha_sched_pkg.sv
// Shared types and defaults for the SHA nonce scheduler.
package sha_sched_pkg;

  localparam int unsigned DEF_TIMEOUT   = 128;
  localparam int unsigned DEF_NONCE_LSB = 96;
  localparam int unsigned MSG_W         = 512;

  typedef logic [255:0]     digest_t;
  typedef logic [31:0]      nonce_t;
  typedef logic [MSG_W-1:0] msg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sha_target_cmp.sv
// Combinational hit test: digest <= target, both 256-bit unsigned.
module sha_target_cmp
  import sha_sched_pkg::*;
(
  input  digest_t digest_i,
  input  digest_t target_i,
  output logic    hit_o
);

  always_comb hit_o = (digest_i <= target_i);

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Sweeps a nonce range through an external SHA engine and reports the first hit.
// Optional hash counter enabled by defining SHA_SCHED_STATS_EN.
module sha_nonce_scheduler
  import sha_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned NONCE_LSB = DEF_NONCE_LSB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] msg_template,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic [511:0] sha_msg,
  output logic         sha_begin,
  output logic         sha_enable,
  input  logic         sha_complete,
  input  logic [255:0] sha_digest,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         timeout_err,
  output logic         done,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_digest,
  output logic [31:0]  hash_count
);

  localparam int unsigned    TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  WAIT_LAST = TW'(TIMEOUT - 1);

  state_e        state_q;
  nonce_t        nonce_q;
  nonce_t        nonce_end_q;
  digest_t       target_q;
  msg_t          sha_msg_q;
  logic          sha_begin_q;
  logic          sha_enable_q;
  logic          busy_q;
  logic          found_q;
  logic          exhausted_q;
  logic          timeout_err_q;
  logic          done_q;
  nonce_t        found_nonce_q;
  digest_t       found_digest_q;
  logic [TW-1:0] wait_q;
  logic          hit;
  logic          start_acc;

  function automatic msg_t with_nonce(input msg_t m, input nonce_t n);
    msg_t r;
    r = m;
    r[NONCE_LSB +: 32] = n;
    return r;
  endfunction

  sha_target_cmp u_cmp (
    .digest_i (sha_digest),
    .target_i (target_q),
    .hit_o    (hit)
  );

  // abort in IDLE suppresses a coincident start
  assign start_acc = (state_q == ST_IDLE) && start && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      nonce_q        <= '0;
      nonce_end_q    <= '0;
      target_q       <= '0;
      sha_msg_q      <= '0;
      sha_begin_q    <= 1'b0;
      sha_enable_q   <= 1'b0;
      busy_q         <= 1'b0;
      found_q        <= 1'b0;
      exhausted_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
      done_q         <= 1'b0;
      found_nonce_q  <= '0;
      found_digest_q <= '0;
      wait_q         <= '0;
    end else begin
      sha_begin_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            state_q        <= ST_LOAD;
            nonce_q        <= nonce_start;
            nonce_end_q    <= nonce_end;
            target_q       <= target;
            sha_msg_q      <= with_nonce(msg_template, nonce_start);
            found_q        <= 1'b0;
            exhausted_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            found_nonce_q  <= '0;
            found_digest_q <= '0;
            busy_q         <= 1'b1;
            sha_begin_q    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q      <= ST_RUN;
            sha_enable_q <= 1'b1;
            wait_q       <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            sha_enable_q <= 1'b0;
          end else if (sha_complete) begin
            state_q      <= ST_CHECK;
            sha_enable_q <= 1'b0;
          end else if (wait_q == WAIT_LAST) begin
            state_q       <= ST_DONE;
            sha_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            done_q        <= 1'b1;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (hit) begin
            state_q        <= ST_DONE;
            busy_q         <= 1'b0;
            done_q         <= 1'b1;
            found_q        <= 1'b1;
            found_nonce_q  <= nonce_q;
            found_digest_q <= sha_digest;
          end else if (nonce_q == nonce_end_q) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            exhausted_q <= 1'b1;
          end else begin
            // the only in-sweep template edit is the nonce field, so rewrite it in place
            state_q     <= ST_LOAD;
            nonce_q     <= nonce_q + 32'd1;
            sha_msg_q   <= with_nonce(sha_msg_q, nonce_q + 32'd1);
            sha_begin_q <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SHA_SCHED_STATS_EN
  logic [31:0] hash_count_q;
  logic [31:0] hash_count_d;

  always_comb begin
    hash_count_d = hash_count_q;
    if (start_acc) begin
      hash_count_d = '0;
    end else if ((state_q == ST_CHECK) && !abort && (hash_count_q != '1)) begin
      hash_count_d = hash_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hash_count_q <= '0;
    else     hash_count_q <= hash_count_d;
  end

  assign hash_count = hash_count_q;
`else
  assign hash_count = '0;
`endif

  assign sha_msg      = sha_msg_q;
  assign sha_begin    = sha_begin_q;
  assign sha_enable   = sha_enable_q;
  assign busy         = busy_q;
  assign found        = found_q;
  assign exhausted    = exhausted_q;
  assign timeout_err  = timeout_err_q;
  assign done         = done_q;
  assign found_nonce  = found_nonce_q;
  assign found_digest = found_digest_q;

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed/randomized bench for sha_nonce_scheduler with a behavioural SHA engine and sweep model.
module tb_sha_nonce_scheduler;

  localparam int unsigned NL = 96;
  localparam int unsigned TO = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [511:0] msg_template = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [255:0] target = '0;
  logic [511:0] sha_msg;
  logic         sha_begin, sha_enable;
  logic         sha_complete = 1'b0;
  logic [255:0] sha_digest = '0;
  logic         busy, found, exhausted, timeout_err, done;
  logic [31:0]  found_nonce, hash_count;
  logic [255:0] found_digest;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sha_nonce_scheduler #(.TIMEOUT(TO), .NONCE_LSB(NL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .msg_template(msg_template), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .sha_msg(sha_msg), .sha_begin(sha_begin), .sha_enable(sha_enable),
    .sha_complete(sha_complete), .sha_digest(sha_digest), .busy(busy), .found(found),
    .exhausted(exhausted), .timeout_err(timeout_err), .done(done),
    .found_nonce(found_nonce), .found_digest(found_digest), .hash_count(hash_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [31:0]  salt = 32'h5A5A_0001;
  bit           never_complete = 1'b0;
  int           begins = 0;
  logic [31:0]  seen[$];
  logic [31:0]  exp_q[$];
  bit           ef, eexh;
  logic [31:0]  efn;
  logic [511:0] tmpl;

  function automatic logic [255:0] digest_of(input logic [31:0] n);
    logic [31:0] x;
    x = n * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    return {x, {7{x ^ salt}}};
  endfunction

  function automatic logic [31:0] exp_hc(input int n);
`ifdef SHA_SCHED_STATS_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  // behavioural engine: random 1..6 cycle latency, digest valid from complete onward
  int          run_cnt, lat;
  bit          live = 1'b0;
  logic [31:0] cur_n;
  always @(negedge clk) begin
    if (rst) begin
      live = 1'b0;
      sha_complete = 1'b0;
    end else if (sha_begin) begin
      begins++;
      cur_n = sha_msg[NL +: 32];
      seen.push_back(cur_n);
      run_cnt = 0;
      lat = $urandom_range(1, 6);
      live = 1'b1;
      sha_complete = 1'b0;
      sha_digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end else if (sha_enable && live && !never_complete) begin
      run_cnt++;
      if (run_cnt == lat) begin
        sha_complete = 1'b1;
        sha_digest = digest_of(cur_n);
        live = 1'b0;
      end
    end else begin
      sha_complete = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
    logic [31:0] n;
    exp_q.delete();
    ef = 1'b0; eexh = 1'b0; efn = '0; n = s;
    for (int k = 0; k < 64; k++) begin
      exp_q.push_back(n);
      if (digest_of(n) <= tgt) begin ef = 1'b1; efn = n; break; end
      if (n == e) begin eexh = 1'b1; break; end
      n = n + 32'd1;
    end
  endtask

  task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt,
                           output bit got_done);
    for (int k = 0; k < 16; k++) tmpl[k*32 +: 32] = $urandom;
    model(s, e, tgt);
    msg_template = tmpl; nonce_start = s; nonce_end = e; target = tgt;
    begins = 0; seen.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin got_done = 1'b1; break; end
      @(negedge clk);
    end
    if (got_done) @(negedge clk);
  endtask

  task automatic verify(input string tag, input bit got_done);
    logic [511:0] em;
    check($sformatf("%s.done_seen", tag), 512'(got_done), 512'(1));
    check($sformatf("%s.done_1cyc", tag), 512'(done), 512'(0));
    check($sformatf("%s.busy", tag), 512'(busy), 512'(0));
    check($sformatf("%s.found", tag), 512'(found), 512'(ef));
    check($sformatf("%s.exhausted", tag), 512'(exhausted), 512'(eexh));
    check($sformatf("%s.timeout_err", tag), 512'(timeout_err), 512'(0));
    if (ef) begin
      check($sformatf("%s.found_nonce", tag), 512'(found_nonce), 512'(efn));
      check($sformatf("%s.found_digest", tag), 512'(found_digest), 512'(digest_of(efn)));
    end
    check($sformatf("%s.hash_count", tag), 512'(hash_count), 512'(exp_hc(exp_q.size())));
    check($sformatf("%s.begins", tag), 512'(begins), 512'(exp_q.size()));
    check($sformatf("%s.n_nonces", tag), 512'(seen.size()), 512'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++)
      check($sformatf("%s.nonce%0d", tag, i), 512'(seen[i]), 512'(exp_q[i]));
    em = tmpl;
    em[NL +: 32] = exp_q[exp_q.size()-1];
    check($sformatf("%s.sha_msg", tag), sha_msg, em);
  endtask

  initial begin
    bit          gd;
    int          rt, nrun, dn, bz;
    logic [31:0] s, e;
    logic [255:0] tgt;
    int          len, mode;

    // reset state
    repeat (2) @(negedge clk);
    check("rst.sha_msg", sha_msg, '0);
    check("rst.flags", 512'({busy, found, exhausted, timeout_err, done, sha_begin, sha_enable}), 512'(0));
    check("rst.found_nonce", 512'(found_nonce), 512'(0));
    check("rst.found_digest", 512'(found_digest), 512'(0));
    check("rst.hash_count", 512'(hash_count), 512'(0));
    rst = 1'b0;
    @(negedge clk);

    // all-ones target hits on the first nonce
    run_sweep(32'd5, 32'd9, '1, gd);
    verify("hit_first", gd);
    check("hit_first.nonce5", 512'(found_nonce), 512'(5));

    // zero target never hits: range exhausts
    run_sweep(32'd0, 32'd3, '0, gd);
    verify("exhaust", gd);
    check("exhaust.begins4", 512'(begins), 512'(4));

    // wrap through 0xFFFFFFFF
    run_sweep(32'hFFFF_FFFE, 32'h0000_0001, '0, gd);
    verify("wrap", gd);

    // single-nonce sweep
    run_sweep(32'h1234_5678, 32'h1234_5678, '0, gd);
    verify("single", gd);

    // randomized sweeps
    for (int i = 0; i < 8; i++) begin
      s = $urandom;
      if (i % 2 == 0) s = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      len = $urandom_range(1, 10);
      e = s + 32'(len - 1);
      mode = i % 3;
      if (mode == 0) tgt = digest_of(s + 32'($urandom_range(0, len - 1)));
      else if (mode == 1) tgt = '0;
      else tgt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_sweep(s, e, tgt, gd);
      verify($sformatf("rnd%0d", i), gd);
    end

    // engine stalls: timeout
    never_complete = 1'b1;
    nonce_start = 32'd40; nonce_end = 32'd50; target = '1; begins = 0; seen.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10 && !sha_enable; c++) @(negedge clk);
    check("to.run_entry", 512'(sha_enable), 512'(1));
    rt = cyc;
    for (int c = 0; c < 400 && !done; c++) @(negedge clk);
    check("to.done", 512'(done), 512'(1));
    check("to.latency", 512'(cyc - rt), 512'(TO));
    check("to.timeout_err", 512'(timeout_err), 512'(1));
    check("to.found", 512'(found), 512'(0));
    check("to.exhausted", 512'(exhausted), 512'(0));
    check("to.hash_count", 512'(hash_count), 512'(exp_hc(0)));
    check("to.begins", 512'(begins), 512'(1));
    @(negedge clk);

    // abort on the 10th RUN cycle, with an ignored start while busy
    nonce_start = 32'd100; nonce_end = 32'd200; begins = 0; seen.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nrun = 0;
    for (int c = 0; c < 50; c++) begin
      if (sha_enable) nrun++;
      if (sha_enable && nrun == 3) nonce_start = 32'd7;
      start = sha_enable && (nrun == 3);
      abort = sha_enable && (nrun == 10);
      @(negedge clk);
      if (abort) break;
    end
    abort = 1'b0;
    start = 1'b0;
    check("abort.nrun", 512'(nrun), 512'(10));
    check("abort.busy", 512'(busy), 512'(0));
    check("abort.sha_enable", 512'(sha_enable), 512'(0));
    dn = 0; bz = 0;
    for (int c = 0; c < 20; c++) begin
      dn += int'(done); bz += int'(busy);
      @(negedge clk);
    end
    check("abort.no_done", 512'(dn), 512'(0));
    check("abort.idle", 512'(bz), 512'(0));
    check("abort.begins", 512'(begins), 512'(1));
    check("abort.first_nonce", 512'(seen[0]), 512'(100));
    check("abort.status", 512'({found, exhausted, timeout_err}), 512'(0));

    // start together with abort in IDLE is ignored
    begins = 0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("startabort.busy", 512'(busy), 512'(0));
    check("startabort.begins", 512'(begins), 512'(0));

    // reset mid-RUN clears everything at once
    nonce_start = 32'hABCD_0000; nonce_end = 32'hABCD_00FF; begins = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nrun = 0;
    for (int c = 0; c < 20 && nrun < 5; c++) begin
      @(negedge clk);
      if (sha_enable) nrun++;
    end
    check("mrst.in_run", 512'(nrun), 512'(5));
    #2 rst = 1'b1;
    #1;
    check("mrst.sha_msg", sha_msg, '0);
    check("mrst.flags", 512'({busy, found, exhausted, timeout_err, done, sha_begin, sha_enable}), 512'(0));
    check("mrst.hash_count", 512'(hash_count), 512'(0));
    check("mrst.found_nonce", 512'(found_nonce), 512'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    never_complete = 1'b0;
    dn = 0; bz = 0;
    for (int c = 0; c < 30; c++) begin
      dn += int'(done); bz += int'(busy);
      @(negedge clk);
    end
    check("mrst.no_done", 512'(dn), 512'(0));
    check("mrst.idle", 512'(bz), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha_nonce_scheduler.md
SHA_NONCE_SCHEDULER -- requirements
Module: sha_nonce_scheduler

Interface
REQ-001 Parameter: TIMEOUT, default 128, max cycles in RUN awaiting sha_complete.
REQ-002 Parameter: NONCE_LSB, default 96, bit position of the 32-bit nonce field in the 512-bit message.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: start  in  1  one-cycle pulse launching a sweep; ignored while busy.
REQ-006 Port: abort  in  1  cancel current sweep.
REQ-007 Port: msg_template  in  512  message block; nonce field overwritten.
REQ-008 Port: nonce_start, nonce_end  in  32 each  inclusive sweep bounds.
REQ-009 Port: target  in  256  unsigned hit threshold.
REQ-010 Port: sha_msg  out  512  template with current nonce at [NONCE_LSB+31:NONCE_LSB].
REQ-011 Port: sha_begin, sha_enable  out  1 each  engine restart / run strobes.
REQ-012 Port: sha_complete  in  1; sha_digest  in  256  engine result.
REQ-013 Port: busy, found, exhausted, timeout_err  out  1 each  status.
REQ-014 Port: done  out  1  one-cycle pulse on sweep end.
REQ-015 Port: found_nonce  out  32; found_digest  out  256.
REQ-016 Port: hash_count  out  32  completed hashes (see Configuration).

Function
REQ-017 States: IDLE, LOAD, RUN, CHECK, DONE.
REQ-018 IDLE: start -> LOAD; template, bounds, target latched; nonce<=nonce_start; found/exhausted/timeout_err cleared.
REQ-019 LOAD: sha_begin=1 exactly one cycle, sha_enable=0; -> RUN; wait counter cleared.
REQ-020 RUN: sha_enable=1; sha_complete -> CHECK; counter reaching TIMEOUT -> DONE with timeout_err=1.
REQ-021 CHECK (one cycle): hit if sha_digest <= latched target (256-bit unsigned, bit 255 MSB); hit -> found=1, capture nonce/digest, -> DONE.
REQ-022 CHECK no hit: nonce==nonce_end -> exhausted=1, DONE; else nonce<=nonce+1 mod 2^32, -> LOAD.
REQ-023 Wrap: nonce_start>nonce_end sweeps through 0xFFFFFFFF to 0; start==end hashes one nonce.
REQ-024 DONE: done=1 one cycle; -> IDLE; status and found_* hold until next accepted start.
REQ-025 Per-nonce latency: 1 (LOAD) + RUN cycles + 1 (CHECK).
REQ-026 sha_msg stable from LOAD through CHECK of each nonce.
REQ-027 busy=1 in LOAD, RUN, CHECK.
REQ-028 abort in LOAD/RUN/CHECK -> IDLE next cycle, no done pulse, no status change; abort wins over same-cycle sha_complete; start and abort together in IDLE: start ignored.

Reset
REQ-029 rst: state IDLE; all outputs, nonce, counters 0 (sha_msg 0) asynchronously.
REQ-030 rst mid-sweep discards progress; first post-reset activity requires new start.

Configuration
REQ-031 Macro SHA_SCHED_STATS_EN defined: hash_count increments on each CHECK, cleared on accepted start, saturates at 0xFFFFFFFF.
REQ-032 Macro undefined: hash_count tied 0, counter logic absent; port list unchanged.

Structure
REQ-033 Package sha_sched_pkg: state enum, digest_t (256-bit), nonce_t (32-bit), default TIMEOUT/NONCE_LSB constants.
REQ-034 One sub-module sha_target_cmp: combinational 256-bit digest<=target compare.

Verification
REQ-035 target=all-ones, range 5..9 -> found=1, found_nonce=5, hash_count=1, done pulse.
REQ-036 target=0, range 0..3, engine digest nonzero -> exhausted=1, found=0, 4 sha_begin pulses, hash_count=4.
REQ-037 Range 0xFFFFFFFE..0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 in order on sha_msg field.
REQ-038 Engine model never asserts sha_complete, TIMEOUT=128 -> timeout_err=1, done 128 cycles after RUN entry.
REQ-039 abort on 10th RUN cycle -> IDLE next cycle, sha_enable=0, no done; start during busy ignored.
REQ-040 rst asserted mid-RUN -> all outputs 0 immediately, no done after release.
